// File: rtl/doomsday_pkg.sv
// Shared definitions for the time_counter timekeeping path: state encoding,
// BCD digit width and per-digit maxima.
package doomsday_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_ONES_MAX = BCD_W'(9);
    localparam logic [BCD_W-1:0] BCD_TENS_MAX = BCD_W'(5);

    // Encoding 2'b11 is unused and recovers to ST_STOPPED.
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_SETTING = 2'd2
    } state_e;

endpackage

// File: rtl/time_counter_if.sv
// Control/digit bundle between the debouncer/alarm logic and time_counter.
//   start, set_mode, inc, clear      : controls into the counter
//   current0..current3               : BCD digits ss-ones, ss-tens, mm-ones, mm-tens
//   sec_tick, running, wrap          : status pulses/levels out of the counter
// master = controller side, slave = time_counter side.
interface time_counter_if;
    import doomsday_pkg::*;

    logic             start;
    logic             set_mode;
    logic             inc;
    logic             clear;
    logic [BCD_W-1:0] current0;
    logic [BCD_W-1:0] current1;
    logic [BCD_W-1:0] current2;
    logic [BCD_W-1:0] current3;
    logic             sec_tick;
    logic             running;
    logic             wrap;

    modport master (
        output start, set_mode, inc, clear,
        input  current0, current1, current2, current3, sec_tick, running, wrap
    );

    modport slave (
        input  start, set_mode, inc, clear,
        output current0, current1, current2, current3, sec_tick, running, wrap
    );
endinterface

// File: rtl/tick_gen.sv
// One-second prescaler: counts enabled cycles modulo TICK_DIV and flags the
// terminal cycle combinationally so the caller can act on that same edge.
//   clk, reset : clock, synchronous active-low reset
//   en_i       : count this cycle
//   clr_i      : force the count to zero (wins over en_i)
//   term_c_o   : count is at TICK_DIV-1 and enabled (combinational)
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PRESC_W  = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic term_c_o
);

    localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    assign term_c_o = en_i && (presc_q == TERM);

    // Next prescaler value.
    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = (presc_q == TERM) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// mm:ss BCD timekeeper with run/stop, manual minute setting and clear.
//   clk, reset : clock, synchronous active-low reset
//   tc_if      : time_counter_if.slave (controls in, digits/status out)
// Build option: TIME_COUNTER_COUNTDOWN_EN makes RUNNING ticks count down,
// stopping with a wrap pulse on reaching 00:00.
module time_counter
    import doomsday_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned PRESC_W  = 26
) (
    input  logic          clk,
    input  logic          reset,
    time_counter_if.slave tc_if
);

    state_e           state_q, state_d, state_fsm_c;
    logic [BCD_W-1:0] cur0_q, cur1_q, cur2_q, cur3_q;
    logic [BCD_W-1:0] cur0_d, cur1_d, cur2_d, cur3_d;
    logic             sec_tick_q, sec_tick_d;
    logic             running_q, running_d;
    logic             wrap_q, wrap_d;
    logic             start_ok_c;
    logic             presc_en_c;
    logic             presc_clr_c;
    logic             tick_c;

`ifdef TIME_COUNTER_COUNTDOWN_EN
    // Nothing to count down from at 00:00.
    assign start_ok_c = ({cur3_q, cur2_q, cur1_q, cur0_q} != '0);
`else
    assign start_ok_c = 1'b1;
`endif

    // Mode transitions; clear freezes the mode for its cycle.
    always_comb begin
        state_fsm_c = ST_STOPPED;
        case (state_q)
            ST_STOPPED: begin
                if (tc_if.set_mode) begin
                    state_fsm_c = ST_SETTING;
                end else if (tc_if.start && start_ok_c) begin
                    state_fsm_c = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                state_fsm_c = ST_RUNNING;
                if (tc_if.set_mode) begin
                    state_fsm_c = ST_SETTING;
                end else if (tc_if.start) begin
                    state_fsm_c = ST_STOPPED;
                end
            end
            ST_SETTING: begin
                state_fsm_c = tc_if.set_mode ? ST_SETTING : ST_STOPPED;
            end
            default: state_fsm_c = ST_STOPPED;
        endcase
        if (tc_if.clear) begin
            state_fsm_c = (state_q == ST_RUNNING || state_q == ST_SETTING) ? state_q : ST_STOPPED;
        end
        // Count only while staying in RUNNING; any exit or clear drops a pending tick.
        presc_en_c  = (state_q == ST_RUNNING) && (state_fsm_c == ST_RUNNING) && !tc_if.clear;
        presc_clr_c = tc_if.clear || (state_fsm_c != ST_RUNNING);
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .PRESC_W  (PRESC_W)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en_i     (presc_en_c),
        .clr_i    (presc_clr_c),
        .term_c_o (tick_c)
    );

    // Digit update: clear, then tick, then SETTING entry/inc.
    always_comb begin
        cur0_d     = cur0_q;
        cur1_d     = cur1_q;
        cur2_d     = cur2_q;
        cur3_d     = cur3_q;
        sec_tick_d = 1'b0;
        wrap_d     = 1'b0;
        state_d    = state_fsm_c;
        if (tc_if.clear) begin
            cur0_d = '0;
            cur1_d = '0;
            cur2_d = '0;
            cur3_d = '0;
        end else if (tick_c) begin
            sec_tick_d = 1'b1;
`ifdef TIME_COUNTER_COUNTDOWN_EN
            if (cur0_q != '0) begin
                cur0_d = cur0_q - BCD_W'(1);
            end else begin
                cur0_d = BCD_ONES_MAX;
                if (cur1_q != '0) begin
                    cur1_d = cur1_q - BCD_W'(1);
                end else begin
                    cur1_d = BCD_TENS_MAX;
                    if (cur2_q != '0) begin
                        cur2_d = cur2_q - BCD_W'(1);
                    end else begin
                        cur2_d = BCD_ONES_MAX;
                        cur3_d = (cur3_q != '0) ? cur3_q - BCD_W'(1) : BCD_TENS_MAX;
                    end
                end
            end
            if ({cur3_d, cur2_d, cur1_d, cur0_d} == '0) begin
                wrap_d  = 1'b1;
                state_d = ST_STOPPED;
            end
`else
            if (cur0_q != BCD_ONES_MAX) begin
                cur0_d = cur0_q + BCD_W'(1);
            end else begin
                cur0_d = '0;
                if (cur1_q != BCD_TENS_MAX) begin
                    cur1_d = cur1_q + BCD_W'(1);
                end else begin
                    cur1_d = '0;
                    if (cur2_q != BCD_ONES_MAX) begin
                        cur2_d = cur2_q + BCD_W'(1);
                    end else begin
                        cur2_d = '0;
                        if (cur3_q != BCD_TENS_MAX) begin
                            cur3_d = cur3_q + BCD_W'(1);
                        end else begin
                            cur3_d = '0;
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
`endif
        end else if (state_q != ST_SETTING && state_fsm_c == ST_SETTING) begin
            cur0_d = '0;
            cur1_d = '0;
        end else if (state_q == ST_SETTING && state_fsm_c == ST_SETTING && tc_if.inc) begin
            // Minutes only; 59 -> 00 silently.
            if (cur2_q != BCD_ONES_MAX) begin
                cur2_d = cur2_q + BCD_W'(1);
            end else begin
                cur2_d = '0;
                cur3_d = (cur3_q != BCD_TENS_MAX) ? cur3_q + BCD_W'(1) : '0;
            end
        end
        running_d = (state_d == ST_RUNNING);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_STOPPED;
            cur0_q     <= '0;
            cur1_q     <= '0;
            cur2_q     <= '0;
            cur3_q     <= '0;
            sec_tick_q <= 1'b0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur0_q     <= cur0_d;
            cur1_q     <= cur1_d;
            cur2_q     <= cur2_d;
            cur3_q     <= cur3_d;
            sec_tick_q <= sec_tick_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
        end
    end

    assign tc_if.current0 = cur0_q;
    assign tc_if.current1 = cur1_q;
    assign tc_if.current2 = cur2_q;
    assign tc_if.current3 = cur3_q;
    assign tc_if.sec_tick = sec_tick_q;
    assign tc_if.running  = running_q;
    assign tc_if.wrap     = wrap_q;

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Timekeeping source for the alarm display path. Produces the four BCD "current" digits (mm:ss, 00:00 to 59:59) that the alarm comparator consumes.
- Divides the system clock to a 1 Hz tick, advances the digits with BCD carry, and provides a manual set mode driven by the debounced increase pulse.
- Sits between the PushButton_Debouncer outputs and the alarm/SegDisplay blocks.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second tick; must be >= 2; benches use 4.
- PRESC_W, 26: prescaler counter width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; toggles run/stop.
- set_mode  in  1  level; high = manual set mode.
- inc  in  1  single-cycle debounced pulse; increments minutes in set mode.
- clear  in  1  single-cycle pulse; zeroes all digits.
- current0  out  4  seconds ones, BCD 0-9.
- current1  out  4  seconds tens, BCD 0-5.
- current2  out  4  minutes ones, BCD 0-9.
- current3  out  4  minutes tens, BCD 0-5.
- sec_tick  out  1  registered pulse, high for the one cycle after each digit advance.
- running  out  1  high in RUNNING state.
- wrap  out  1  one-cycle pulse on 59:59 -> 00:00 (countdown build: reaching 00:00).

Behaviour:
- Reset (reset==0 at posedge):
  - state = STOPPED.
  - All digits 0, prescaler 0.
  - sec_tick, running, wrap = 0.
- States:
  - STOPPED:
    - set_mode -> SETTING.
    - Otherwise start -> RUNNING.
  - RUNNING:
    - set_mode -> SETTING.
    - Otherwise start -> STOPPED.
  - SETTING:
    - set_mode low -> STOPPED.
    - start ignored.
  - Unused encodings -> STOPPED.
- Priority per cycle: reset > clear > state transition > tick/inc.
  - clear zeroes the digits and the prescaler but does not change state.
  - clear in the same cycle as a tick or inc: clear wins; the tick/inc is dropped.
- Prescaler:
  - Advances only in RUNNING. Held at 0 in STOPPED/SETTING, so a resumed count always waits a full TICK_DIV cycles.
  - On the edge where prescaler == TICK_DIV-1: prescaler <= 0 and the digits advance on that same edge. sec_tick is therefore high the following cycle, coincident with the new digit values.
  - First advance after start occurs TICK_DIV cycles after the start edge.
- Up-count carry chain (RUNNING tick):
  - current0 9->0 carries into current1.
  - current1 5->0 carries into current2.
  - current2 9->0 carries into current3.
  - current3 5->0 with full carry is the wrap; wrap pulses for one cycle, aligned with sec_tick.
- SETTING:
  - Entering SETTING zeroes current0/current1.
  - Each inc pulse increments minutes: current2 9->0 carries into current3; 59 wraps to 00 with no wrap pulse.
  - inc is ignored outside SETTING.
- running is the registered decode of RUNNING, updating the cycle after the transition edge.
- All outputs are registered; digits never hold non-BCD values.

Optional Feature:
- Macro: TIME_COUNTER_COUNTDOWN_EN.
- Defined:
  - RUNNING ticks decrement with BCD borrow (0->9, tens 0->5).
  - The tick that reaches 00:00 pulses wrap and forces STOPPED.
  - start in STOPPED while the digits are 00:00 is ignored.
  - In SETTING, inc behaviour is unchanged.
- Undefined: up-count as above.

Decomposition:
- Shared package doomsday_pkg holds:
  - state encoding constants ST_STOPPED, ST_RUNNING, ST_SETTING;
  - BCD_W = 4;
  - BCD_ONES_MAX = 9 and BCD_TENS_MAX = 5.
- One natural sub-module: tick_gen (TICK_DIV prescaler with enable and synchronous clear, outputting the terminal-count strobe).
- BCD carry/borrow stays inline.

Test Plan (TICK_DIV=4):
- Reset held low 3 cycles, then start pulse -> digits 0000, running=1 one cycle later, first sec_tick 4 cycles after start with current0=1.
- Preload via set mode to 59:00, run 60 ticks -> 59:59 then 00:00; wrap and sec_tick high the same single cycle.
- Run to 00:09, next tick -> 00:10; run to 09:59, next tick -> 10:00 (carry chain).
- Running at 03:27, raise set_mode -> running=0, seconds 00; 3 inc pulses -> 06:00; inc at 59:00 -> 00:00 with wrap=0; drop set_mode -> STOPPED, digits hold through 20 cycles.
- clear coincident with the terminal prescaler cycle at 12:34 -> digits 00:00, no sec_tick, state unchanged; reset asserted mid-run -> all outputs 0 next edge.
- Countdown build: set 01:00, start -> 00:59 after 4 cycles; at 00:01 next tick -> 00:00, wrap pulse, running=0; further start pulse ignored.
